mux_nway_stream: RTL and testbench

Parametrised, registered N-channel W-bit stream multiplexer with valid/ready handshakes on every input and on the output. It generalises the team's fixed 4-way 16-bit combinational mux into a pipelined selector. Selection is either the explicit `sel` input or optional round-robin arbitration. It sits between multiple data producers (ALU result, memory read, I/O port, constant generator) and a single consumer in the CPU datapath.

---
 rtl/mux_nway_stream.sv | 128 ++++++++++++
 tb/tb_mux_nway_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nway_stream.sv
// Registered N-way valid/ready stream mux; fixed select, plus round-robin arbitration when MUX_NWAY_RR_EN is defined.
// Latency: 1 cycle from input accept to out_data/out_valid/out_chan.
// Backpressure: one output slot; the granted in_ready is !out_valid | out_ready, so a stall freezes the held word.
module mux_nway_stream #(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
`ifdef MUX_NWAY_RR_EN
    input  logic                      rr_mode,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t            state;
    slot_t            state_nxt;
    logic             can_load;
    logic             sel_ok;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) || out_ready;
    // Non-power-of-2 channel counts leave select codes with no channel behind them.
    assign sel_ok    = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));

`ifdef MUX_NWAY_RR_EN
    logic [SEL_W-1:0] last;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;

    // Search upward from last+1, wrapping, so the previous winner has lowest priority.
    always_comb begin
        int               c;
        logic [SEL_W-1:0] idx;
        rr_found = 1'b0;
        rr_grant = '0;
        c        = 0;
        idx      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            c = int'(last) + i;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            idx = SEL_W'(c);
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = idx;
            end
        end
    end
`endif

    always_comb begin
        grant_vld = sel_ok;
        grant     = sel;
`ifdef MUX_NWAY_RR_EN
        if (rr_mode) begin
            grant_vld = rr_found;
            grant     = rr_grant;
        end
`endif
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = !reset && grant_vld && can_load;
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = FULL;
        end else if (out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_chan <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_data <= grant_data;
                out_chan <= grant;
            end
        end
    end

`ifdef MUX_NWAY_RR_EN
    // Reset to the top channel so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= SEL_W'(CHANNELS - 1);
        end else if (rr_mode && xfer) begin
            last <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nway_stream.sv
// Directed bench for mux_nway_stream: 4-channel instance for the main features, 3-channel instance for out-of-range select.
`timescale 1ns/1ps
module tb_mux_nway_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;

    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_chan3;

`ifdef MUX_NWAY_RR_EN
    logic rr_mode;
    logic rr_mode3;
`endif

    mux_nway_stream #(.WIDTH(16), .CHANNELS(4)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
`ifdef MUX_NWAY_RR_EN
        .rr_mode(rr_mode),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    mux_nway_stream #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3),
`ifdef MUX_NWAY_RR_EN
        .rr_mode(rr_mode3),
`endif
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 4'hF; sel = 2'd0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected %b", in_ready, 4'b0000); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
        tick();
        reset = 1'b0; in_valid = 4'h0;
        tick();
    endtask

    task automatic test_fixed_sweep();
        logic [15:0] exp_dat;
        logic [3:0]  exp_rdy;
        in_valid = 4'hF; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            exp_dat = 16'h0001 << s;
            exp_rdy = 4'b0001 << s;
            #1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL sweep_in_ready[%0d]: got %b expected %b", s, in_ready, exp_rdy); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_out_valid[%0d]: got %b expected 1", s, out_valid); end
            checks++; if (out_data !== exp_dat) begin errors++; $display("FAIL sweep_out_data[%0d]: got %h expected %h", s, out_data, exp_dat); end
            checks++; if (out_chan !== 2'(s)) begin errors++; $display("FAIL sweep_out_chan[%0d]: got %0d expected %0d", s, out_chan, s); end
        end
        in_valid = 4'h0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0008) begin errors++; $display("FAIL drain_stale_data: got %h expected 0008", out_data); end
    endtask

    task automatic test_stall();
        in_valid = 4'hF; sel = 2'd2; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL stall_empty_ready: got %b expected 0100", in_ready); end
        tick();
        checks++; if (out_data !== 16'h0004) begin errors++; $display("FAIL stall_load_data: got %h expected 0004", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_load_valid: got %b expected 1", out_valid); end
        sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", i, in_ready); end
            tick();
            checks++; if (out_data !== 16'h0004) begin errors++; $display("FAIL stall_hold_data[%0d]: got %h expected 0004", i, out_data); end
            checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL stall_hold_chan[%0d]: got %0d expected 2", i, out_chan); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL stall_release_ready: got %b expected 1000", in_ready); end
        tick();
        checks++; if (out_data !== 16'h0008) begin errors++; $display("FAIL stall_release_data: got %h expected 0008", out_data); end
        checks++; if (out_chan !== 2'd3) begin errors++; $display("FAIL stall_release_chan: got %0d expected 3", out_chan); end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic pat [3] = '{1'b1, 1'b0, 1'b1};
        sel = 2'd1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = pat[i] ? 4'b0010 : 4'b0000;
            tick();
            checks++; if (out_valid !== pat[i]) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b expected %b", i, out_valid, pat[i]); end
        end
        checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL b2b_out_data: got %h expected 0002", out_data); end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        sel = 2'd3; in_valid = 4'hF; out_ready = 1'b0;
        tick();
        checks++; if (out_data !== 16'h0008) begin errors++; $display("FAIL mid_stall_full_data: got %h expected 0008", out_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stall_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_stall_data: got %h expected 0000", out_data); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL mid_stall_chan: got %0d expected 0", out_chan); end
`ifdef MUX_NWAY_RR_EN
        rr_mode = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL mid_stall_rr_first: got %0d expected 0", out_chan); end
        checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL mid_stall_rr_data: got %h expected 0001", out_data); end
        rr_mode = 1'b0;
`endif
        in_valid = 4'h0; out_ready = 1'b1;
        tick();
    endtask

`ifdef MUX_NWAY_RR_EN
    task automatic test_round_robin();
        logic [1:0] exp_all [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] exp_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        logic [15:0] exp_dat;
        reset = 1'b1;
        tick();
        reset = 1'b0; rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            exp_dat = 16'h0001 << exp_all[i];
            tick();
            checks++; if (out_chan !== exp_all[i]) begin errors++; $display("FAIL rr_all_chan[%0d]: got %0d expected %0d", i, out_chan, exp_all[i]); end
            checks++; if (out_data !== exp_dat) begin errors++; $display("FAIL rr_all_data[%0d]: got %h expected %h", i, out_data, exp_dat); end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            exp_dat = 16'h0001 << exp_odd[i];
            tick();
            checks++; if (out_data !== exp_dat) begin errors++; $display("FAIL rr_odd_data[%0d]: got %h expected %h", i, out_data, exp_dat); end
        end
        in_valid = 4'h0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready: got %b expected 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_valid: got %b expected 0", out_valid); end
        in_valid = 4'hF;
        tick();
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL rr_after_idle_chan: got %0d expected 0", out_chan); end
        rr_mode = 1'b0; sel = 2'd2;
        tick();
        checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL rr_switch_fixed_chan: got %0d expected 2", out_chan); end
        rr_mode = 1'b1;
        tick();
        checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL rr_switch_back_chan: got %0d expected 1", out_chan); end
        in_valid = 4'h0; rr_mode = 1'b0;
        tick();
    endtask
`endif

    task automatic test_out_of_range();
        in_valid3 = 3'b111; sel3 = 2'd3; out_ready3 = 1'b1;
        #1;
        checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL oor_in_ready: got %b expected 000", in_ready3); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL oor_out_valid[%0d]: got %b expected 0", i, out_valid3); end
        end
        sel3 = 2'd2;
        #1;
        checks++; if (in_ready3 !== 3'b100) begin errors++; $display("FAIL oor_top_ready: got %b expected 100", in_ready3); end
        tick();
        checks++; if (out_data3 !== 16'h0004) begin errors++; $display("FAIL oor_top_data: got %h expected 0004", out_data3); end
        checks++; if (out_chan3 !== 2'd2) begin errors++; $display("FAIL oor_top_chan: got %0d expected 2", out_chan3); end
        in_valid3 = 3'b000;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
        in_valid   = 4'h0;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = {16'h0004, 16'h0002, 16'h0001};
        in_valid3  = 3'b000;
        sel3       = 2'd0;
        out_ready3 = 1'b1;
`ifdef MUX_NWAY_RR_EN
        rr_mode    = 1'b0;
        rr_mode3   = 1'b0;
`endif
        test_reset();
        test_fixed_sweep();
        test_stall();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef MUX_NWAY_RR_EN
        test_round_robin();
`endif
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
